axis_noc_injector_mc: RTL and testbench
=======================================

Name: axis_noc_injector_mc

Overview:
Multi-channel AXI-Stream injection stage for a NoC router local port. It generalises the single-stream injection path to NUM_CHANNELS independent AXIS masters. Packets are arbitrated round-robin with a packet-level lock, so a packet's flits are never interleaved with another packet's. Output flits use the router's native data/dest/is_tail/send/credit interface, with credit-based flow control against the router input buffer (FLIT_BUFFER_DEPTH entries).

Parameters:
NUM_CHANNELS, 4, number of AXIS input channels (>=1)
TDATA_WIDTH, 128, AXIS data width = flit width (no serialization)
TID_WIDTH, 2, AXIS tid width
TDEST_WIDTH, 2, AXIS tdest width
DEST_WIDTH, TID_WIDTH+TDEST_WIDTH, router dest field width
FLIT_BUFFER_DEPTH, 2, downstream buffer depth = initial credit count (>=1)
CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width
CH_WIDTH, max(1,$clog2(NUM_CHANNELS)), channel index width

Ports:
clk_noc  in  1  NoC clock; one clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
axis_in_tvalid  in  [NUM_CHANNELS]  per-channel valid
axis_in_tready  out  [NUM_CHANNELS]  per-channel ready
axis_in_tdata  in  [NUM_CHANNELS][TDATA_WIDTH]  per-channel data
axis_in_tlast  in  [NUM_CHANNELS]  per-channel end of packet
axis_in_tid  in  [NUM_CHANNELS][TID_WIDTH]  per-channel tid
axis_in_tdest  in  [NUM_CHANNELS][TDEST_WIDTH]  per-channel tdest
data_out  out  TDATA_WIDTH  flit payload
dest_out  out  DEST_WIDTH  {tid,tdest} of the flit
is_tail_out  out  1  last flit of packet
send_out  out  1  flit valid, one-cycle strobe
credit_in  in  1  one credit returned per cycle high
credit_count  out  CREDIT_WIDTH  current credits
active_ch  out  CH_WIDTH  granted channel (valid when locked)
locked  out  1  a packet is mid-transfer
err_credit_overflow  out  1  sticky: credit returned while counter full

Behaviour:
- Reset (async assert, sync-released use): send_out=0, is_tail_out=0, data_out=0, dest_out=0, credit_count=FLIT_BUFFER_DEPTH, locked=0, active_ch=0, rr pointer=0, err_credit_overflow=0. axis_in_tready=0 while rst_n=0.
- can_send = (credit_count != 0). Same-cycle credit_in does not feed can_send; this avoids a combinational credit path.
- Arbitration when locked=0: grant the first channel with tvalid=1, searching round-robin from (last_granted+1) mod NUM_CHANNELS. The search is combinational. No grant if no tvalid.
- axis_in_tready[i] = can_send && ((locked && active_ch==i) || (!locked && grant==i)). All other channels' ready is 0.
- Handshake on channel i (tvalid&tready):
  - next cycle send_out=1
  - data_out=tdata[i], dest_out={tid[i],tdest[i]}, is_tail_out=tlast[i]
  - latency exactly 1 cycle
- Lock: a handshake with tlast=0 sets locked=1 and active_ch=i. A handshake with tlast=1 clears locked and sets last_granted=i. A single-beat packet never sets locked. While locked, other channels' tvalid is ignored.
- Locked and active channel's tvalid=0: hold the lock and emit no flit; the bubble is allowed.
- Credits: credit_count_next = credit_count - send_fire + credit_in, where send_fire = any handshake.
  - Simultaneous handshake and credit_in: count unchanged.
  - Count 0 with credit_in: count becomes 1 next cycle; ready rises then.
  - credit_in with count==FLIT_BUFFER_DEPTH and no handshake: count saturates, err_credit_overflow=1 until reset.
- Without a handshake, send_out=0 next cycle. data_out/dest_out/is_tail_out hold their last value and is_tail_out is 0 when send_out=0.
- Reset mid-packet: lock dropped; the partial packet is abandoned, and upstream/downstream reset together by system contract.
- tdata/tid/tdest of the active channel may change only on handshake, per AXIS rules. The block does not check this.

Decomposition:
- Package noc_injector_pkg: flit struct typedef {data, dest, is_tail}; localparams for DEST_WIDTH/CREDIT_WIDTH derivation helpers.
- Sub-module rr_lock_arbiter: NUM_CHANNELS requests, lock/unlock inputs, one-hot+index grant, rotating pointer.
- Top holds the credit counter, output register and tready logic.

Test Plan:
1. Reset then idle, no credit_in: credit_count=2, send_out=0, all tready=0 until a tvalid. No credit traffic must leave the count at 2 with no error.
2. Ch1 sends a 3-flit packet (tdata 0xA,0xB,0xC; tid=1, tdest=2) while ch0 is valid, FLIT_BUFFER_DEPTH=2, credit_in pulsed 1 cycle after each send:
   - send_out pulses carry 0xA,0xB,0xC with dest_out=4'b0110
   - is_tail_out only on 0xC
   - ch0 tready=0 until after tail; ch0 is then granted.
3. No credit_in, ch0 streams 4 flits: exactly 2 flits sent, credit_count=0, tready=0. One credit_in pulse: the third flit goes out 2 cycles after the pulse.
4. All 4 channels hold single-beat packets continuously, credit_in returned every cycle: grant order 0,1,2,3,0,… with one flit per cycle, credit_count stable at 1.
5. credit_in pulsed at count=2 with no traffic: count stays 2, err_credit_overflow=1 and stays set. Simultaneous send and credit_in at count=1: count stays 1.
6. rst_n asserted mid-packet (after flit 1 of 3 on ch2): locked=0, send_out=0 immediately. After release, ch0 is granted first and credit_count=2.

Source files
------------

// File: rtl/noc_injector_pkg.sv
// Shared types and width helpers for the multi-channel AXIS NoC injector.
package noc_injector_pkg;

    localparam int DEF_TDATA_WIDTH = 128;
    localparam int DEF_TID_WIDTH   = 2;
    localparam int DEF_TDEST_WIDTH = 2;
    localparam int DEF_DEST_WIDTH  = DEF_TID_WIDTH + DEF_TDEST_WIDTH;

    // One router flit at the default widths: payload, {tid,tdest} route, tail marker.
    typedef struct packed {
        logic [DEF_TDATA_WIDTH-1:0] data;
        logic [DEF_DEST_WIDTH-1:0]  dest;
        logic                       is_tail;
    } flit_t;

    // Router dest field is the AXIS tid concatenated with tdest.
    function automatic int calc_dest_width(input int tid_w, input int tdest_w);
        return tid_w + tdest_w;
    endfunction

    // Enough bits to hold every value from 0 up to the full buffer depth.
    function automatic int calc_credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int calc_ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a packet lock: once a non-tail beat is accepted the
// grant stays on that channel until its tail beat is accepted.
module rr_lock_arbiter
    import noc_injector_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_WIDTH     = calc_ch_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic                    fire,
    input  logic                    fire_last,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic [CH_WIDTH-1:0]     grant_idx,
    output logic                    grant_valid,
    output logic                    locked,
    output logic [CH_WIDTH-1:0]     active_ch
);

    // rr_ptr is the first channel the search looks at, i.e. last_granted+1.
    logic [CH_WIDTH-1:0] rr_ptr;
    logic [CH_WIDTH-1:0] search_idx;
    logic                search_hit;
    logic [CH_WIDTH-1:0] cand_idx;
    logic [CH_WIDTH-1:0] ptr_after;
    int                  cand_wide;

    // Find the first requesting channel starting at the rotating pointer.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        cand_wide  = 0;
        cand_idx   = '0;
        for (int off = 0; off < NUM_CHANNELS; off++) begin
            cand_wide = int'(rr_ptr) + off;
            if (cand_wide >= NUM_CHANNELS) begin
                cand_wide = cand_wide - NUM_CHANNELS;
            end
            cand_idx = CH_WIDTH'(cand_wide);
            if (!search_hit && req[cand_idx]) begin
                search_hit = 1'b1;
                search_idx = cand_idx;
            end
        end
    end

    // A held lock overrides the search; otherwise the search result is the grant.
    always_comb begin
        grant       = '0;
        grant_idx   = search_idx;
        grant_valid = search_hit;
        if (locked) begin
            grant_idx   = active_ch;
            grant_valid = 1'b1;
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer position just past the channel that finishes a packet.
    always_comb begin
        ptr_after = grant_idx + CH_WIDTH'(1);
        if (grant_idx == CH_WIDTH'(NUM_CHANNELS - 1)) begin
            ptr_after = '0;
        end
    end

    // Lock on a non-tail beat, release and rotate on a tail beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked    <= 1'b0;
            active_ch <= '0;
            rr_ptr    <= '0;
        end else if (fire) begin
            if (fire_last) begin
                locked <= 1'b0;
                rr_ptr <= ptr_after;
            end else begin
                locked    <= 1'b1;
                active_ch <= grant_idx;
            end
        end
    end

endmodule

// File: rtl/axis_noc_injector_mc.sv
// Multi-channel AXIS to NoC local-port injector with packet-locked round-robin
// arbitration and credit-based flow control against the router input buffer.
module axis_noc_injector_mc
    import noc_injector_pkg::*;
#(
    parameter int NUM_CHANNELS      = 4,
    parameter int TDATA_WIDTH       = 128,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 2,
    parameter int DEST_WIDTH        = calc_dest_width(TID_WIDTH, TDEST_WIDTH),
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CREDIT_WIDTH      = calc_credit_width(FLIT_BUFFER_DEPTH),
    parameter int CH_WIDTH          = calc_ch_width(NUM_CHANNELS)
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_n,
    input  logic [NUM_CHANNELS-1:0]                  axis_in_tvalid,
    output logic [NUM_CHANNELS-1:0]                  axis_in_tready,
    input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic [NUM_CHANNELS-1:0]                  axis_in_tlast,
    input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   axis_in_tid,
    input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] axis_in_tdest,
    output logic [TDATA_WIDTH-1:0]                   data_out,
    output logic [DEST_WIDTH-1:0]                    dest_out,
    output logic                                     is_tail_out,
    output logic                                     send_out,
    input  logic                                     credit_in,
    output logic [CREDIT_WIDTH-1:0]                  credit_count,
    output logic [CH_WIDTH-1:0]                      active_ch,
    output logic                                     locked,
    output logic                                     err_credit_overflow
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

    logic [NUM_CHANNELS-1:0] grant;
    logic [CH_WIDTH-1:0]     grant_idx;
    logic                    grant_valid;
    logic                    can_send;
    logic                    send_fire;

    rr_lock_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_WIDTH     (CH_WIDTH)
    ) u_arb (
        .clk         (clk_noc),
        .rst_n       (rst_n),
        .req         (axis_in_tvalid),
        .fire        (send_fire),
        .fire_last   (axis_in_tlast[grant_idx]),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .locked      (locked),
        .active_ch   (active_ch)
    );

    // Only the registered count gates ready, so credit_in never reaches tready combinationally.
    always_comb begin
        can_send       = (credit_count != '0);
        axis_in_tready = '0;
        if (rst_n && can_send && grant_valid) begin
            axis_in_tready = grant;
        end
        send_fire = |(axis_in_tvalid & axis_in_tready);
    end

    // Credit counter: spend one per accepted beat, regain one per credit_in, saturate at depth.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_count        <= CREDIT_MAX;
            err_credit_overflow <= 1'b0;
        end else begin
            case ({send_fire, credit_in})
                2'b10: credit_count <= credit_count - CREDIT_ONE;
                2'b01: begin
                    if (credit_count == CREDIT_MAX) begin
                        err_credit_overflow <= 1'b1;
                    end else begin
                        credit_count <= credit_count + CREDIT_ONE;
                    end
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

    // Flit output register: one-cycle strobe, payload holds between flits, tail only with a strobe.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            is_tail_out <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
        end else begin
            send_out <= send_fire;
            if (send_fire) begin
                data_out    <= axis_in_tdata[grant_idx];
                dest_out    <= {axis_in_tid[grant_idx], axis_in_tdest[grant_idx]};
                is_tail_out <= axis_in_tlast[grant_idx];
            end else begin
                is_tail_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_noc_injector_mc.sv
// Directed self-checking bench for axis_noc_injector_mc at default parameters.
module tb_axis_noc_injector_mc;

    logic                   clk_noc = 1'b0;
    logic                   rst_n   = 1'b0;
    logic [3:0]             axis_in_tvalid = '0;
    logic [3:0]             axis_in_tready;
    logic [3:0][127:0]      axis_in_tdata  = '0;
    logic [3:0]             axis_in_tlast  = '0;
    logic [3:0][1:0]        axis_in_tid    = '0;
    logic [3:0][1:0]        axis_in_tdest  = '0;
    logic [127:0]           data_out;
    logic [3:0]             dest_out;
    logic                   is_tail_out;
    logic                   send_out;
    logic                   credit_in = 1'b0;
    logic [1:0]             credit_count;
    logic [1:0]             active_ch;
    logic                   locked;
    logic                   err_credit_overflow;

    int vectors     = 0;
    int miscompares = 0;

    axis_noc_injector_mc dut (
        .clk_noc             (clk_noc),
        .rst_n               (rst_n),
        .axis_in_tvalid      (axis_in_tvalid),
        .axis_in_tready      (axis_in_tready),
        .axis_in_tdata       (axis_in_tdata),
        .axis_in_tlast       (axis_in_tlast),
        .axis_in_tid         (axis_in_tid),
        .axis_in_tdest       (axis_in_tdest),
        .data_out            (data_out),
        .dest_out            (dest_out),
        .is_tail_out         (is_tail_out),
        .send_out            (send_out),
        .credit_in           (credit_in),
        .credit_count        (credit_count),
        .active_ch           (active_ch),
        .locked              (locked),
        .err_credit_overflow (err_credit_overflow)
    );

    // Free-running NoC clock.
    always #5 clk_noc = ~clk_noc;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic valid, input logic last,
                                 input logic [127:0] data, input logic [1:0] id, input logic [1:0] dst);
        axis_in_tvalid[ch] = valid;
        axis_in_tlast[ch]  = last;
        axis_in_tdata[ch]  = data;
        axis_in_tid[ch]    = id;
        axis_in_tdest[ch]  = dst;
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // ---- 1: reset and idle ----
        axis_in_tvalid = 4'b1111;
        #2;
        checkOutput("rst_tready", axis_in_tready, 4'b0000);
        tick();
        checkOutput("rst_send", send_out, 1'b0);
        checkOutput("rst_credit", credit_count, 2'd2);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_active", active_ch, 2'd0);
        checkOutput("rst_err", err_credit_overflow, 1'b0);
        checkOutput("rst_tail", is_tail_out, 1'b0);
        checkOutput("rst_data", data_out, 128'h0);
        axis_in_tvalid = 4'b0000;
        rst_n = 1'b1;
        tick(); tick(); tick();
        checkOutput("idle_credit", credit_count, 2'd2);
        checkOutput("idle_err", err_credit_overflow, 1'b0);
        checkOutput("idle_send", send_out, 1'b0);
        checkOutput("idle_tready", axis_in_tready, 4'b0000);

        // ---- single-beat on ch0 moves the pointer to ch1 ----
        applyStimulus(0, 1'b1, 1'b1, 128'h55, 2'd0, 2'd3);
        #1;
        checkOutput("pre_tready", axis_in_tready, 4'b0001);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 128'h0, 2'd0, 2'd0);
        checkOutput("pre_send", send_out, 1'b1);
        checkOutput("pre_data", data_out, 128'h55);
        checkOutput("pre_dest", dest_out, 4'b0011);
        checkOutput("pre_tail", is_tail_out, 1'b1);
        checkOutput("pre_credit", credit_count, 2'd1);
        checkOutput("pre_locked", locked, 1'b0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checkOutput("pre_credit_back", credit_count, 2'd2);
        checkOutput("pre_send_low", send_out, 1'b0);
        checkOutput("pre_tail_low", is_tail_out, 1'b0);
        checkOutput("pre_data_hold", data_out, 128'h55);

        // ---- 2: ch1 three-flit packet while ch0 waits ----
        applyStimulus(0, 1'b1, 1'b1, 128'h77, 2'd0, 2'd0);
        applyStimulus(1, 1'b1, 1'b0, 128'hA, 2'd1, 2'd2);
        #1;
        checkOutput("p2_tready_a", axis_in_tready, 4'b0010);
        tick();
        checkOutput("p2_send_a", send_out, 1'b1);
        checkOutput("p2_data_a", data_out, 128'hA);
        checkOutput("p2_dest_a", dest_out, 4'b0110);
        checkOutput("p2_tail_a", is_tail_out, 1'b0);
        checkOutput("p2_locked_a", locked, 1'b1);
        checkOutput("p2_active_a", active_ch, 2'd1);
        checkOutput("p2_credit_a", credit_count, 2'd1);
        applyStimulus(1, 1'b1, 1'b0, 128'hB, 2'd1, 2'd2);
        credit_in = 1'b1;
        #1;
        checkOutput("p2_tready_b", axis_in_tready, 4'b0010);
        tick();
        checkOutput("p2_data_b", data_out, 128'hB);
        checkOutput("p2_tail_b", is_tail_out, 1'b0);
        checkOutput("p2_credit_b", credit_count, 2'd1);
        applyStimulus(1, 1'b1, 1'b1, 128'hC, 2'd1, 2'd2);
        #1;
        checkOutput("p2_tready_c", axis_in_tready, 4'b0010);
        tick();
        checkOutput("p2_send_c", send_out, 1'b1);
        checkOutput("p2_data_c", data_out, 128'hC);
        checkOutput("p2_tail_c", is_tail_out, 1'b1);
        checkOutput("p2_locked_c", locked, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 128'h0, 2'd0, 2'd0);
        #1;
        checkOutput("p2_tready_ch0", axis_in_tready, 4'b0001);
        tick();
        checkOutput("p2_data_ch0", data_out, 128'h77);
        checkOutput("p2_dest_ch0", dest_out, 4'b0000);
        checkOutput("p2_credit_ch0", credit_count, 2'd1);
        applyStimulus(0, 1'b0, 1'b0, 128'h0, 2'd0, 2'd0);
        tick();
        credit_in = 1'b0;
        checkOutput("p2_credit_end", credit_count, 2'd2);
        checkOutput("p2_send_end", send_out, 1'b0);

        // ---- 3: credit starvation on ch0 ----
        applyStimulus(0, 1'b1, 1'b0, 128'h100, 2'd0, 2'd1);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 128'h101, 2'd0, 2'd1);
        tick();
        checkOutput("p3_data_2", data_out, 128'h101);
        checkOutput("p3_credit_0", credit_count, 2'd0);
        applyStimulus(0, 1'b1, 1'b0, 128'h102, 2'd0, 2'd1);
        #1;
        checkOutput("p3_tready_0", axis_in_tready, 4'b0000);
        tick();
        checkOutput("p3_stall_send", send_out, 1'b0);
        checkOutput("p3_stall_locked", locked, 1'b1);
        tick();
        checkOutput("p3_stall_send2", send_out, 1'b0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checkOutput("p3_pulse_send", send_out, 1'b0);
        checkOutput("p3_pulse_credit", credit_count, 2'd1);
        #1;
        checkOutput("p3_tready_1", axis_in_tready, 4'b0001);
        tick();
        checkOutput("p3_send_3", send_out, 1'b1);
        checkOutput("p3_data_3", data_out, 128'h102);
        checkOutput("p3_credit_3", credit_count, 2'd0);
        applyStimulus(0, 1'b1, 1'b1, 128'h103, 2'd0, 2'd1);
        credit_in = 1'b1;
        tick();
        checkOutput("p3_wait_send", send_out, 1'b0);
        tick();
        checkOutput("p3_data_4", data_out, 128'h103);
        checkOutput("p3_tail_4", is_tail_out, 1'b1);
        checkOutput("p3_credit_4", credit_count, 2'd1);
        applyStimulus(0, 1'b0, 1'b0, 128'h0, 2'd0, 2'd0);
        tick();
        credit_in = 1'b0;
        checkOutput("p3_credit_end", credit_count, 2'd2);

        // ---- 4: four channels of single-beat packets, credits every cycle ----
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b1, 1'b1, 128'h10 + 128'(i), 2'(i), 2'(3 - i));
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            credit_in = 1'b1;
            checkOutput($sformatf("p4_send_%0d", k), send_out, 1'b1);
            checkOutput($sformatf("p4_data_%0d", k), data_out, 128'h10 + 128'(k % 4));
            checkOutput($sformatf("p4_dest_%0d", k), dest_out, {2'(k % 4), 2'(3 - (k % 4))});
            checkOutput($sformatf("p4_credit_%0d", k), credit_count, 2'd1);
        end
        axis_in_tvalid = 4'b0000;
        tick();
        credit_in = 1'b0;
        checkOutput("p4_credit_end", credit_count, 2'd2);
        checkOutput("p4_send_end", send_out, 1'b0);

        // ---- 5: credit overflow and simultaneous send/credit ----
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checkOutput("p5_ovf_credit", credit_count, 2'd2);
        checkOutput("p5_ovf_err", err_credit_overflow, 1'b1);
        tick();
        checkOutput("p5_ovf_sticky", err_credit_overflow, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 128'h5A, 2'd0, 2'd0);
        tick();
        checkOutput("p5_credit_1", credit_count, 2'd1);
        credit_in = 1'b1;
        tick();
        checkOutput("p5_simul_send", send_out, 1'b1);
        checkOutput("p5_simul_credit", credit_count, 2'd1);
        applyStimulus(0, 1'b0, 1'b0, 128'h0, 2'd0, 2'd0);
        tick();
        credit_in = 1'b0;
        checkOutput("p5_credit_end", credit_count, 2'd2);
        checkOutput("p5_err_still", err_credit_overflow, 1'b1);

        // ---- 6: reset in the middle of a ch2 packet ----
        applyStimulus(2, 1'b1, 1'b0, 128'h200, 2'd2, 2'd1);
        tick();
        checkOutput("p6_send_1", send_out, 1'b1);
        checkOutput("p6_locked_1", locked, 1'b1);
        checkOutput("p6_active_1", active_ch, 2'd2);
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 128'h300, 2'd3, 2'd3);
        applyStimulus(2, 1'b1, 1'b1, 128'h201, 2'd2, 2'd1);
        #1;
        checkOutput("p6_rst_locked", locked, 1'b0);
        checkOutput("p6_rst_send", send_out, 1'b0);
        checkOutput("p6_rst_credit", credit_count, 2'd2);
        checkOutput("p6_rst_err", err_credit_overflow, 1'b0);
        checkOutput("p6_rst_tready", axis_in_tready, 4'b0000);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("p6_tready_ch0", axis_in_tready, 4'b0001);
        tick();
        checkOutput("p6_data_ch0", data_out, 128'h300);
        checkOutput("p6_dest_ch0", dest_out, 4'b1111);
        checkOutput("p6_credit_ch0", credit_count, 2'd1);
        axis_in_tvalid = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
